imm_decode_stage: RTL and testbench

Two-deep decode pipeline stage between instruction fetch and execute. Captures each 9-bit instruction and, for load-immediate instructions, drives the 4-bit immediate-table index out to the constant LUT. It registers the 8-bit constant returned, plus opcode and fields, toward execute under a valid/ready handshake. It also flags and counts out-of-range table indices.

---
 rtl/imm_decode_stage_pkg.sv | 13 +
 rtl/imm_decode_stage.sv | 78 +++++++
 tb/tb_imm_decode_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg: shared opcode, legal-index limit and decoded-entry type for the decode stage
package imm_decode_stage_pkg;
  localparam logic [3:0] OP_LDI = 4'b1111;
  localparam logic [3:0] LUT_LEGAL_MAX = 4'd11;
  localparam int IMM_W = 8;
  typedef struct packed {
    logic [3:0] opcode;
    logic [4:0] operand;
    logic is_imm;
    logic [IMM_W-1:0] imm;
    logic err;
  } entry_t;
endpackage

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: two-deep decode pipeline resolving load-immediate constants through an external LUT
//   clk/rst_n            clock, async active-low reset
//   in_valid/in_ready    fetch-side handshake, instr = {opcode[8:5], operand[4:0]}
//   flush                synchronous squash of both stages
//   lut_addr/lut_target  combinational LUT lookup from stage A
//   out_*                registered decoded entry toward execute, out_valid/out_ready handshake
//   err_count            saturating count of illegal-index LDIs delivered
module imm_decode_stage import imm_decode_stage_pkg::*; #(
  parameter int IW = 9,
  parameter int DW = IMM_W,
  parameter int ERRW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   instr,
  input  logic            flush,
  output logic [3:0]      lut_addr,
  input  logic [DW-1:0]   lut_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_op,
  output logic [4:0]      out_operand,
  output logic            out_is_imm,
  output logic [DW-1:0]   out_imm,
  output logic            out_err,
  output logic [ERRW-1:0] err_count
);
  logic a_valid;
  logic [3:0] a_op;
  logic [4:0] a_operand;
  logic a_adv, a_ldi, a_legal;
  entry_t b, dec;
  assign a_adv = a_valid && (!out_valid || out_ready);
  assign in_ready = !a_valid || a_adv;
  assign a_ldi = a_op == OP_LDI;
  assign a_legal = a_operand[3:0] <= LUT_LEGAL_MAX;
  // illegal indices never reach the LUT
  assign lut_addr = a_valid && a_ldi && a_legal ? a_operand[3:0] : 4'd0;
  always_comb begin
    dec.opcode = a_op;
    dec.operand = a_operand;
    dec.is_imm = a_ldi;
    dec.imm = a_ldi && a_legal ? lut_target : '0;
    dec.err = a_ldi && !a_legal;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_op <= '0;
      a_operand <= '0;
    end else begin
      a_valid <= !flush && ((in_valid && in_ready) || (a_valid && !a_adv));
      if (in_valid && in_ready) begin
        a_op <= instr[IW-1 -: 4];
        a_operand <= instr[4:0];
      end
    end
  end
  // a handshake in a flush cycle still counts toward err_count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      b <= '0;
      err_count <= '0;
    end else begin
      out_valid <= !flush && (a_adv || (out_valid && !out_ready));
      if (a_adv) b <= dec;
      if (out_valid && out_ready && b.err && err_count != '1) err_count <= err_count + ERRW'(1);
    end
  end
  assign out_op = b.opcode;
  assign out_operand = b.operand;
  assign out_is_imm = b.is_imm;
  assign out_imm = b.imm;
  assign out_err = b.err;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed plus randomized scoreboard bench for imm_decode_stage
module tb_imm_decode_stage;
  typedef struct {
    logic [3:0] op;
    logic [4:0] opd;
    logic is_imm;
    logic [7:0] imm;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [8:0] instr = '0;
  logic flush = 1'b0;
  logic [3:0] lut_addr;
  logic [7:0] lut_target;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [3:0] out_op;
  logic [4:0] out_operand;
  logic out_is_imm;
  logic [7:0] out_imm;
  logic out_err;
  logic [3:0] err_count;
  exp_t q[$];
  int pass = 0;
  int total = 0;
  int exp_err = 0;
  imm_decode_stage #(.IW(9), .DW(8), .ERRW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .lut_addr(lut_addr), .lut_target(lut_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_operand(out_operand), .out_is_imm(out_is_imm),
    .out_imm(out_imm), .out_err(out_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] lut_val(input logic [3:0] i);
    logic [7:0] tab [16];
    tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h0F, 8'hF0, 8'hAA, 8'hFF, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
    return tab[i];
  endfunction
  assign lut_target = lut_val(lut_addr);
  function automatic exp_t model(input logic [8:0] ins);
    exp_t e;
    int idx;
    idx = int'(ins[3:0]);
    e.op = ins[8:5];
    e.opd = ins[4:0];
    e.is_imm = ins[8:5] == 4'hF;
    e.err = e.is_imm && idx >= 12;
    e.imm = e.is_imm && idx < 12 ? lut_val(ins[3:0]) : 8'h00;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [8:0] ldi(input int idx);
    return {4'hF, 5'(idx)};
  endfunction
  task automatic drive(input logic iv, input logic [8:0] ins, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = iv;
    instr = ins;
    out_ready = ordy;
    flush = fl;
    #2;
    chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !ordy)));
    if (iv && in_ready && !fl) q.push_back(model(ins));
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("lut_addr_legal", 32'(lut_addr < 4'd12), 32'd1);
        if (out_valid) begin
          if (q.size() == 0) begin
            total++;
            $display("FAIL spurious_out: got op=%0h imm=%0h expected no entry", out_op, out_imm);
          end else begin
            chk("out_op", 32'(out_op), 32'(q[0].op));
            chk("out_operand", 32'(out_operand), 32'(q[0].opd));
            chk("out_is_imm", 32'(out_is_imm), 32'(q[0].is_imm));
            chk("out_imm", 32'(out_imm), 32'(q[0].imm));
            chk("out_err", 32'(out_err), 32'(q[0].err));
            if (out_ready) begin
              if (q[0].err && exp_err < 15) exp_err++;
              void'(q.pop_front());
            end
          end
        end
        if (flush) q.delete();
      end
    end
  end
  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {out_op, out_operand, out_is_imm, out_imm, out_err, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // latency and streaming of legal LDIs
    drive(1, ldi(0), 1, 0);
    drive(1, ldi(3), 1, 0);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    drive(1, ldi(7), 1, 0);
    chk("lat_first_valid", 32'(out_valid), 32'd1);
    chk("stream_imm0", 32'(out_imm), 32'h01);
    drive(0, 0, 1, 0);
    chk("stream_imm1", 32'(out_imm), 32'h08);
    drive(0, 0, 1, 0);
    chk("stream_imm2", 32'(out_imm), 32'h80);
    drive(0, 0, 1, 0);
    // legal boundary then illegal index
    drive(1, ldi(11), 1, 0);
    drive(1, ldi(13), 1, 0);
    chk("lut_addr_11", 32'(lut_addr), 32'd11);
    drive(0, 0, 1, 0);
    chk("lut_addr_illegal", 32'(lut_addr), 32'd0);
    chk("imm_11", 32'(out_imm), 32'hFF);
    chk("err_11", 32'(out_err), 32'd0);
    drive(0, 0, 1, 0);
    chk("imm_13", 32'(out_imm), 32'h00);
    chk("err_13", 32'(out_err), 32'd1);
    drive(0, 0, 1, 0);
    chk("err_count_1", 32'(err_count), 32'd1);
    // non-LDI
    drive(1, 9'b0010_10101, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("nonldi_fields", {out_valid, out_is_imm, out_imm, out_op, out_operand}, {1'b1, 1'b0, 8'h00, 4'b0010, 5'b10101});
    drive(0, 0, 1, 0);
    // stall with input pressure
    drive(1, ldi(0), 0, 0);
    drive(1, ldi(1), 0, 0);
    drive(1, ldi(2), 0, 0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_b_hold", {out_valid, out_imm}, {1'b1, 8'h01});
    drive(1, ldi(2), 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("stall_drained", 32'(q.size()), 32'd0);
    // flush with both stages full and a same-cycle input handshake
    drive(1, ldi(4), 0, 0);
    drive(1, ldi(5), 0, 0);
    drive(1, ldi(6), 1, 1);
    drive(1, ldi(9), 1, 0);
    chk("flush_empty", 32'(out_valid), 32'd0);
    drive(0, 0, 1, 0);
    chk("flush_refill_1", 32'(out_valid), 32'd0);
    drive(0, 0, 1, 0);
    chk("flush_refill_2", {out_valid, out_imm}, {1'b1, 8'hF0});
    drive(0, 0, 1, 0);
    // error counter saturation
    for (int i = 0; i < 16; i++) drive(1, ldi(12 + (i % 4)), 1, 0);
    repeat (3) drive(0, 0, 1, 0);
    chk("err_saturate", 32'(err_count), 32'd15);
    // reset mid-stream
    drive(1, ldi(1), 1, 0);
    drive(1, ldi(2), 1, 0);
    drive(1, ldi(14), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {out_valid, out_op, out_operand, out_is_imm, out_imm, out_err, err_count}, 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    q.delete();
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] ins;
      ins = {($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom), 5'($urandom)};
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) drive(0, 0, 1, 0);
    chk("final_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
